// File: rtl/stopwatch_display.sv
// Stopwatch display encoder.
// Captures binary seconds and milliseconds counts on a load strobe and clamps them.
// Two lockstep double-dabble engines convert the values to BCD.
// The digits are then latched as active-low 7-segment patterns in the form "SS-mmm".
module stopwatch_display #(
    parameter int S_MAX         = 99,
    parameter int MS_MAX        = 999,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [9:0] segundos,
    input  logic [9:0] mili_segundos,
    output logic       busy,
    output logic       done,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0
);

    localparam logic [9:0] S_MAX_W  = 10'(S_MAX);
    localparam logic [9:0] MS_MAX_W = 10'(MS_MAX);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] LAST_SHIFT = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [9:0]  s_bin;
    logic [9:0]  ms_bin;
    logic [7:0]  s_bcd;
    logic [11:0] ms_bcd;

    logic [9:0]  s_clamped;
    logic [9:0]  ms_clamped;
    logic [7:0]  s_adj;
    logic [11:0] ms_adj;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after doubling.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern. Any non-decimal nibble shows as blank.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Clamp inputs so that a counter rollover value never reaches the engine.
    always_comb begin
        s_clamped  = (segundos > S_MAX_W) ? S_MAX_W : segundos;
        ms_clamped = (mili_segundos > MS_MAX_W) ? MS_MAX_W : mili_segundos;
    end

    // Apply the add-3 correction to every BCD nibble before the next shift.
    always_comb begin
        s_adj  = {add3(s_bcd[7:4]), add3(s_bcd[3:0])};
        ms_adj = {add3(ms_bcd[11:8]), add3(ms_bcd[7:4]), add3(ms_bcd[3:0])};
    end

    assign busy = (state != IDLE);

    // Conversion FSM: capture, ten shift-add-3 steps, then latch the segment outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            s_bin  <= '0;
            ms_bin <= '0;
            s_bcd  <= '0;
            ms_bcd <= '0;
            done   <= 1'b0;
            hex5   <= SEG_BLANK;
            hex4   <= SEG_BLANK;
            hex3   <= SEG_BLANK;
            hex2   <= SEG_BLANK;
            hex1   <= SEG_BLANK;
            hex0   <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        s_bin  <= s_clamped;
                        ms_bin <= ms_clamped;
                        s_bcd  <= '0;
                        ms_bcd <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_bcd  <= {s_adj[6:0], s_bin[9]};
                    s_bin  <= {s_bin[8:0], 1'b0};
                    ms_bcd <= {ms_adj[10:0], ms_bin[9]};
                    ms_bin <= {ms_bin[8:0], 1'b0};
                    cnt    <= cnt + 4'd1;
                    if (cnt == LAST_SHIFT) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if ((BLANK_LEADING != 0) && (s_bcd[7:4] == 4'd0)) begin
                        hex5 <= SEG_BLANK;
                    end else begin
                        hex5 <= seg7(s_bcd[7:4]);
                    end
                    hex4  <= seg7(s_bcd[3:0]);
                    hex3  <= SEG_DASH;
                    hex2  <= seg7(ms_bcd[11:8]);
                    hex1  <= seg7(ms_bcd[7:4]);
                    hex0  <= seg7(ms_bcd[3:0]);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display. It checks reset, conversion latency, digit
// encoding, leading-zero blanking, clamping, back-to-back loads and mid-conversion reset.
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [9:0] segundos;
    logic [9:0] mili_segundos;
    logic       busy, done;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       busy_nb, done_nb;
    logic [6:0] nb5, nb4, nb3, nb2, nb1, nb0;

    int checks = 0;
    int errors = 0;

    stopwatch_display #(.S_MAX(99), .MS_MAX(999), .BLANK_LEADING(1)) dut (
        .clk(clk), .rst(rst), .load(load),
        .segundos(segundos), .mili_segundos(mili_segundos),
        .busy(busy), .done(done),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    stopwatch_display #(.S_MAX(99), .MS_MAX(999), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .load(load),
        .segundos(segundos), .mili_segundos(mili_segundos),
        .busy(busy_nb), .done(done_nb),
        .hex5(nb5), .hex4(nb4), .hex3(nb3), .hex2(nb2), .hex1(nb1), .hex0(nb0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one load, then count edges until done. While busy, the task scrambles the
    // inputs and drives load so that both can be shown to have no effect.
    task automatic convert(input logic [9:0] s, input logic [9:0] ms, input bit noisy,
                           output int lat);
        segundos      = s;
        mili_segundos = ms;
        load          = 1'b1;
        tick();
        load = 1'b0;
        lat  = 0;
        while (!done && lat < 30) begin
            if (noisy) begin
                segundos      = 10'($urandom_range(0, 1023));
                mili_segundos = 10'($urandom_range(0, 1023));
                load          = 1'b1;
            end
            tick();
            lat++;
        end
        load = 1'b0;
    endtask

    logic [41:0] exp10 [3];
    int lat;
    int ndone;

    initial begin
        exp10[0] = {7'h79, 7'h40, 7'h3F, 7'h79, 7'h40, 7'h40};
        exp10[1] = {7'h24, 7'h24, 7'h3F, 7'h79, 7'h79, 7'h24};
        exp10[2] = {7'h30, 7'h19, 7'h3F, 7'h79, 7'h24, 7'h19};

        // Step 1: reset and idle
        rst = 1'b1; load = 1'b0; segundos = '0; mili_segundos = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        for (int i = 0; i < 20; i++) tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));

        // Step 2: 42-317 with noisy inputs and load during busy
        segundos = 10'd42; mili_segundos = 10'd317; load = 1'b1;
        tick();
        load = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
        check("hold_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        rst = 1'b1; tick(); rst = 1'b0;
        convert(10'd42, 10'd317, 1'b1, lat);
        check("lat_42", 64'(lat), 64'd11);
        check("hex_42_317", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h19, 7'h24, 7'h3F, 7'h30, 7'h79, 7'h78}));
        tick();
        check("done_pulse", 64'(done), 64'd0);
        check("idle_after", 64'(busy), 64'd0);

        // Step 3: leading blank
        convert(10'd5, 10'd7, 1'b0, lat);
        check("lat_5", 64'(lat), 64'd11);
        check("hex_5_7_bl1", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h7F, 7'h12, 7'h3F, 7'h40, 7'h40, 7'h78}));
        check("hex_5_7_bl0", 64'({nb5, nb4, nb3, nb2, nb1, nb0}),
              64'({7'h40, 7'h12, 7'h3F, 7'h40, 7'h40, 7'h78}));
        tick();

        // Step 4: clamp and zero
        convert(10'd100, 10'd1000, 1'b0, lat);
        check("hex_clamp", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h10, 7'h10, 7'h3F, 7'h10, 7'h10, 7'h10}));
        tick();
        convert(10'd1023, 10'd1023, 1'b0, lat);
        check("hex_clamp_max", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h10, 7'h10, 7'h3F, 7'h10, 7'h10, 7'h10}));
        tick();
        convert(10'd0, 10'd0, 1'b0, lat);
        check("hex_zero", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h7F, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h40}));
        check("hex_zero_bl0", 64'({nb5, nb4, nb3, nb2, nb1, nb0}),
              64'({7'h40, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h40}));
        tick();

        // Step 5: load held high, inputs changing every cycle
        load  = 1'b1;
        ndone = 0;
        for (int k = 0; k < 36; k++) begin
            segundos      = 10'(10 + k);
            mili_segundos = 10'(100 + k);
            tick();
            if (k % 12 == 11) begin
                check($sformatf("cont_done_%0d", k), 64'(done), 64'd1);
                check($sformatf("cont_hex_%0d", k),
                      64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(exp10[k / 12]));
            end
            if (done) ndone++;
        end
        load = 1'b0;
        check("cont_count", 64'(ndone), 64'd3);
        tick();

        // Step 6: reset in the middle of a conversion
        segundos = 10'd42; mili_segundos = 10'd317; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        convert(10'd58, 10'd46, 1'b0, lat);
        check("lat_after_abort", 64'(lat), 64'd11);
        check("hex_58_046", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h12, 7'h00, 7'h3F, 7'h40, 7'h19, 7'h02}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
